branch_predictor: RTL and testbench

// - Dynamic branch predictor. Produces predict_signal for NPCMux in the IF stage and is

---
 rtl/branch_predictor_pkg.sv | 19 +
 rtl/branch_predictor_sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 94 +++++++++
 tb/tb_branch_predictor.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the 2-bit saturating-counter branch predictor.
// Counter states, the reset state and a helper that maps a state to a taken/not-taken prediction.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_state_e;

    localparam bp_state_e BP_RESET_STATE = BP_WNT;

    // The counter's MSB is the prediction: WT and ST predict taken.
    function automatic logic bp_taken(input logic [1:0] state);
        return state[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next state of a 2-bit saturating counter.
// The counter moves up on taken, down on not taken, and holds at ST and SNT.
module bp_sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != BP_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != BP_SNT) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT of 2-bit counters: predicts in IF, trains from ID resolution,
// flags mispredictions and keeps saturating performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      lookup_pc,
    output logic             predict_signal,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic             upd_predicted,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic [1:0]            bht_reg [ENTRIES];
    logic [ENTRIES-1:0]    bht_we;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_nxt;
    logic                  bypass;
    logic                  mispredict_hit;
    logic                  mispredict_reg;
    logic [CNT_W-1:0]      branch_cnt_reg;
    logic [CNT_W-1:0]      mispredict_cnt_reg;
    logic                  unused_pc_bits;

    assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
    assign upd_idx    = upd_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                              upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

    assign upd_cur = bht_reg[upd_idx];

    bp_sat_counter2 u_sat_counter2 (
        .cur   (upd_cur),
        .taken (upd_taken),
        .nxt   (upd_nxt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_bht_we
            assign bht_we[gi] = upd_valid && (upd_idx == INDEX_BITS'(gi));
        end
    endgenerate

    // Flop array rather than RAM so reset can restore every entry in one cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (rst) begin
                bht_reg[i] <= BP_RESET_STATE;
            end else if (bht_we[i]) begin
                bht_reg[i] <= upd_nxt;
            end
        end
    end

    // Same-index update forwards its new counter so a tight loop sees its own training.
    assign bypass         = upd_valid && !rst && (upd_idx == lookup_idx);
    assign predict_signal = bypass ? bp_taken(upd_nxt) : bp_taken(bht_reg[lookup_idx]);

    assign mispredict_hit = upd_valid && (upd_taken != upd_predicted);

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_reg     <= 1'b0;
            branch_cnt_reg     <= '0;
            mispredict_cnt_reg <= '0;
        end else begin
            mispredict_reg <= mispredict_hit;
            if (upd_valid && (branch_cnt_reg != '1)) begin
                branch_cnt_reg <= branch_cnt_reg + 1'b1;
            end
            if (mispredict_hit && (mispredict_cnt_reg != '1)) begin
                mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
            end
        end
    end

    assign mispredict     = mispredict_reg;
    assign branch_cnt     = branch_cnt_reg;
    assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: reset, training, saturation,
// bypass, aliasing, mispredict pulses and counters, reset priority over update.
`timescale 1ns/1ps
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        predict_signal;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_predicted;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.INDEX_BITS(6), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_pc      (lookup_pc),
        .predict_signal (predict_signal),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_predicted  (upd_predicted),
        .mispredict     (mispredict),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            $display("check %s: observed=0x%0h expected=0x%0h ok", tag, obs, exp);
        end else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clocked update; outputs are sampled 1 ns after the edge.
    task automatic update(input logic [31:0] pc, input logic taken, input logic predicted);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_taken     = taken;
        upd_predicted = predicted;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic predict_at(input string tag, input logic [31:0] pc, input logic exp);
        lookup_pc = pc;
        #1;
        check(tag, {31'd0, predict_signal}, {31'd0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic exp_misp [10];

    initial begin
        rst           = 1'b1;
        lookup_pc     = 32'h0040_0000;
        upd_valid     = 1'b0;
        upd_pc        = 32'h0;
        upd_taken     = 1'b0;
        upd_predicted = 1'b0;

        // Reset: all entries WNT, counters zero.
        do_reset();
        check("rst_branch_cnt", branch_cnt, 32'd0);
        check("rst_misp_cnt", mispredict_cnt, 32'd0);
        check("rst_mispredict", {31'd0, mispredict}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            predict_at($sformatf("rst_predict_idx%0d", i), 32'h0040_0000 + 32'(i * 4), 1'b0);
        end

        // Training on idx 4: WNT -> WT -> ST (x3) -> WT -> WNT.
        update(32'h0040_0010, 1'b1, 1'b0);
        predict_at("train_taken1", 32'h0040_0010, 1'b1);
        repeat (3) update(32'h0040_0010, 1'b1, 1'b1);
        update(32'h0040_0010, 1'b0, 1'b1);
        predict_at("train_nt1", 32'h0040_0010, 1'b1);
        update(32'h0040_0010, 1'b0, 1'b1);
        predict_at("train_nt2", 32'h0040_0010, 1'b0);

        // Saturation: from WNT, 5 NT -> SNT, then taken -> WNT.
        repeat (5) update(32'h0040_0010, 1'b0, 1'b0);
        update(32'h0040_0010, 1'b1, 1'b0);
        predict_at("sat_low", 32'h0040_0010, 1'b0);
        repeat (5) update(32'h0040_0010, 1'b1, 1'b1);
        update(32'h0040_0010, 1'b0, 1'b1);
        predict_at("sat_high", 32'h0040_0010, 1'b1);

        // Bypass on idx 8 (WNT): taken update visible combinationally.
        predict_at("bypass_before", 32'h0040_0020, 1'b0);
        upd_pc        = 32'h0040_0020;
        upd_taken     = 1'b1;
        upd_predicted = 1'b0;
        upd_valid     = 1'b1;
        predict_at("bypass_same_cycle", 32'h0040_0020, 1'b1);
        predict_at("bypass_other_idx", 32'h0040_0024, 1'b0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        predict_at("bypass_after", 32'h0040_0020, 1'b1);

        // Aliasing: 0x0040_0104 shares idx 1 with 0x0040_0004.
        update(32'h0040_0004, 1'b1, 1'b0);
        update(32'h0040_0004, 1'b1, 1'b1);
        predict_at("alias_same_idx", 32'h0040_0104, 1'b1);
        predict_at("alias_other_idx", 32'h0040_0008, 1'b0);

        // Mispredict pulses and counters over 10 updates, mispredicts at 2, 5, 7.
        do_reset();
        for (int i = 0; i < 10; i++) exp_misp[i] = (i == 2 || i == 5 || i == 7);
        for (int i = 0; i < 10; i++) begin
            logic tk;
            tk = (i % 2) == 0;
            update(32'h0040_0080 + 32'(i * 4), tk, exp_misp[i] ? !tk : tk);
            check($sformatf("misp_pulse%0d", i), {31'd0, mispredict}, {31'd0, exp_misp[i]});
        end
        @(posedge clk);
        #1;
        check("misp_idle", {31'd0, mispredict}, 32'd0);
        check("cnt_branch", branch_cnt, 32'd10);
        check("cnt_misp", mispredict_cnt, 32'd3);

        // Mid-sequence reset wipes counters and drops the coincident update.
        update(32'h0040_0030, 1'b1, 1'b0);
        check("pre_rst_branch_cnt", branch_cnt, 32'd11);
        check("pre_rst_misp_cnt", mispredict_cnt, 32'd4);
        rst           = 1'b1;
        upd_valid     = 1'b1;
        upd_pc        = 32'h0040_0030;
        upd_taken     = 1'b1;
        upd_predicted = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        upd_valid = 1'b0;
        check("mid_rst_branch_cnt", branch_cnt, 32'd0);
        check("mid_rst_misp_cnt", mispredict_cnt, 32'd0);
        check("mid_rst_mispredict", {31'd0, mispredict}, 32'd0);
        predict_at("mid_rst_dropped_upd", 32'h0040_0030, 1'b0);
        predict_at("mid_rst_table_clear", 32'h0040_0010, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst_branch_cnt", branch_cnt, 32'd0);
        check("post_rst_mispredict", {31'd0, mispredict}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
